// File: rtl/fdc_pipe_pkg.sv
// -----------------------------------------------------------------------------
// fdc_pipe_pkg
// Shared definitions for the fdc_pipe delay line:
//   - fill_width(depth) : width of the FILL counter, clog2(depth+1)
//   - tap_width(depth)  : width of the optional TAP select, max(1, clog2(depth))
//   - stage_op_e / stage_op() : per-edge action decode (SR > CE > hold)
// Optional feature macro used by the top: FDC_PIPE_TAP_EN.
// -----------------------------------------------------------------------------
package fdc_pipe_pkg;

    typedef enum logic [1:0] {
        OP_HOLD  = 2'd0,
        OP_SHIFT = 2'd1,
        OP_SRST  = 2'd2
    } stage_op_e;

    function automatic int fill_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int tap_width(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

    // Synchronous reset outranks the clock enable.
    function automatic stage_op_e stage_op(input logic sr, input logic ce);
        if (sr) return OP_SRST;
        if (ce) return OP_SHIFT;
        return OP_HOLD;
    endfunction

endpackage

// File: rtl/fdc_stage.sv
// -----------------------------------------------------------------------------
// fdc_stage
// One pipeline stage: a WIDTH-bit data register plus its valid bit.
// Async clear loads {INIT, 0}; at a rising clock edge SR loads {INIT, 0},
// otherwise CE loads {d_i, v_i}, otherwise the stage holds.
// Ports:
//   c_i    clock (rising edge)
//   clr_i  asynchronous active-high clear
//   ce_i   clock enable
//   sr_i   synchronous active-high reset
//   d_i    data in          v_i  valid in
//   q_o    registered data  v_o  registered valid
// -----------------------------------------------------------------------------
module fdc_stage
    import fdc_pipe_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] INIT  = {WIDTH{1'b0}}
) (
    input  logic             c_i,
    input  logic             clr_i,
    input  logic             ce_i,
    input  logic             sr_i,
    input  logic [WIDTH-1:0] d_i,
    input  logic             v_i,
    output logic [WIDTH-1:0] q_o,
    output logic             v_o
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             vld_q,  vld_d;

    always_comb begin
        data_d = data_q;
        vld_d  = vld_q;
        case (stage_op(sr_i, ce_i))
            OP_SRST: begin
                data_d = INIT;
                vld_d  = 1'b0;
            end
            OP_SHIFT: begin
                data_d = d_i;
                vld_d  = v_i;
            end
            default: ;
        endcase
    end

    always_ff @(posedge c_i or posedge clr_i) begin
        if (clr_i) begin
            data_q <= INIT;
            vld_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            vld_q  <= vld_d;
        end
    end

    assign q_o = data_q;
    assign v_o = vld_q;

endmodule

// File: rtl/fdc_pipe.sv
// -----------------------------------------------------------------------------
// fdc_pipe
// WIDTH-bit x DEPTH-stage stallable delay line with per-stage valid tracking
// and a count of valid stages. Data shifts on every enabled edge regardless
// of VIN; valid is bookkeeping only.
// Ports:
//   C     clock, rising edge
//   CLR   asynchronous active-high clear (all stages to INIT/invalid, FILL=0)
//   CE    clock enable
//   SR    synchronous active-high reset (wins over CE)
//   D     data into stage 0,  VIN  valid qualifier for D
//   Q     data of last stage, VOUT valid of last stage
//   FILL  number of stages holding valid data (0..DEPTH)
// Optional (macro FDC_PIPE_TAP_EN):
//   TAP   stage select
//   TQ/TV combinational data/valid of stage TAP; INIT/0 when TAP >= DEPTH
// -----------------------------------------------------------------------------
module fdc_pipe
    import fdc_pipe_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter int               DEPTH = 4,
    parameter logic [WIDTH-1:0] INIT  = {WIDTH{1'b0}}
) (
    input  logic                              C,
    input  logic                              CLR,
    input  logic                              CE,
    input  logic                              SR,
    input  logic [WIDTH-1:0]                  D,
    input  logic                              VIN,
    output logic [WIDTH-1:0]                  Q,
    output logic                              VOUT,
    output logic [fill_width(DEPTH)-1:0]      FILL
`ifdef FDC_PIPE_TAP_EN
    ,
    input  logic [tap_width(DEPTH)-1:0]       TAP,
    output logic [WIDTH-1:0]                  TQ,
    output logic                              TV
`endif
);

    localparam int FILL_MAX = DEPTH;
    localparam int FW       = fill_width(DEPTH);

    if (FILL_MAX < 1) begin : g_depth_chk
        $error("fdc_pipe: DEPTH must be at least 1");
    end

    logic [WIDTH-1:0] data_q [DEPTH];
    logic [DEPTH-1:0] vld_q;
    logic [FW-1:0]    fill_q, fill_d;

    // Stage chain: stage 0 takes the inputs, stage i takes stage i-1.
    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        if (i == 0) begin : g_first
            fdc_stage #(.WIDTH(WIDTH), .INIT(INIT)) u_stage (
                .c_i   (C),
                .clr_i (CLR),
                .ce_i  (CE),
                .sr_i  (SR),
                .d_i   (D),
                .v_i   (VIN),
                .q_o   (data_q[i]),
                .v_o   (vld_q[i])
            );
        end else begin : g_next
            fdc_stage #(.WIDTH(WIDTH), .INIT(INIT)) u_stage (
                .c_i   (C),
                .clr_i (CLR),
                .ce_i  (CE),
                .sr_i  (SR),
                .d_i   (data_q[i-1]),
                .v_i   (vld_q[i-1]),
                .q_o   (data_q[i]),
                .v_o   (vld_q[i])
            );
        end
    end

    // Fill counter: one valid enters with VIN while the old last-stage valid
    // leaves, so the count stays within 0..DEPTH without saturation logic.
    always_comb begin
        fill_d = fill_q;
        case (stage_op(SR, CE))
            OP_SRST:  fill_d = '0;
            OP_SHIFT: fill_d = fill_q + FW'(VIN) - FW'(vld_q[DEPTH-1]);
            default:  ;
        endcase
    end

    always_ff @(posedge C or posedge CLR) begin
        if (CLR) begin
            fill_q <= '0;
        end else begin
            fill_q <= fill_d;
        end
    end

    assign Q    = data_q[DEPTH-1];
    assign VOUT = vld_q[DEPTH-1];
    assign FILL = fill_q;

`ifdef FDC_PIPE_TAP_EN
    localparam int TW = tap_width(DEPTH);

    // Compare against every legal index so an out-of-range select simply
    // matches nothing and falls back to INIT/invalid.
    always_comb begin
        TQ = INIT;
        TV = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (TAP == TW'(i)) begin
                TQ = data_q[i];
                TV = vld_q[i];
            end
        end
    end
`endif

endmodule

// File: tb/tb_fdc_pipe.sv
// -----------------------------------------------------------------------------
// tb_fdc_pipe
// Bench for fdc_pipe. A DEPTH=4 and a DEPTH=1 instance share all inputs; with
// FDC_PIPE_TAP_EN defined a DEPTH=3 instance with TAP fixed at 3 is added.
// The reference keeps the list of words accepted on enabled edges since the
// last clear/reset; stage s of any depth holds the word accepted s enabled
// edges before the newest one, or INIT/invalid when no such word exists.
// -----------------------------------------------------------------------------
module tb_fdc_pipe;

    localparam logic [7:0] INIT = 8'hA5;

    logic       C = 1'b0;
    logic       CLR, CE, SR, VIN;
    logic [7:0] D;

    logic [7:0] q_a, q_b;
    logic       v_a, v_b;
    logic [2:0] f_a;
    logic [0:0] f_b;

`ifdef FDC_PIPE_TAP_EN
    logic [1:0] tap_a;
    logic [7:0] tq_a, tq_b, tq_c, q_c;
    logic       tv_a, tv_b, tv_c, v_c;
    logic [1:0] f_c;
`endif

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    logic [7:0] acc_d [$];
    logic       acc_v [$];

    always #5 C = ~C;

    fdc_pipe #(.WIDTH(8), .DEPTH(4), .INIT(INIT)) u_dut4 (
        .C(C), .CLR(CLR), .CE(CE), .SR(SR), .D(D), .VIN(VIN),
        .Q(q_a), .VOUT(v_a), .FILL(f_a)
`ifdef FDC_PIPE_TAP_EN
        , .TAP(tap_a), .TQ(tq_a), .TV(tv_a)
`endif
    );

    fdc_pipe #(.WIDTH(8), .DEPTH(1), .INIT(INIT)) u_dut1 (
        .C(C), .CLR(CLR), .CE(CE), .SR(SR), .D(D), .VIN(VIN),
        .Q(q_b), .VOUT(v_b), .FILL(f_b)
`ifdef FDC_PIPE_TAP_EN
        , .TAP(1'b0), .TQ(tq_b), .TV(tv_b)
`endif
    );

`ifdef FDC_PIPE_TAP_EN
    fdc_pipe #(.WIDTH(8), .DEPTH(3), .INIT(INIT)) u_dut3 (
        .C(C), .CLR(CLR), .CE(CE), .SR(SR), .D(D), .VIN(VIN),
        .Q(q_c), .VOUT(v_c), .FILL(f_c),
        .TAP(2'd3), .TQ(tq_c), .TV(tv_c)
    );
`endif

    // Reference: remember accepted words; a clear or reset forgets them all.
    always @(posedge C or posedge CLR) begin
        if (CLR || SR) begin
            acc_d.delete();
            acc_v.delete();
        end else if (CE) begin
            acc_d.push_back(D);
            acc_v.push_back(VIN);
            if (acc_d.size() > 8) begin
                void'(acc_d.pop_front());
                void'(acc_v.pop_front());
            end
        end
    end

    function automatic logic [7:0] m_dat(input int s);
        int k;
        k = acc_d.size() - 1 - s;
        return (k >= 0) ? acc_d[k] : INIT;
    endfunction

    function automatic logic m_vld(input int s);
        int k;
        k = acc_v.size() - 1 - s;
        return (k >= 0) ? acc_v[k] : 1'b0;
    endfunction

    function automatic int m_fill(input int depth);
        int n;
        n = 0;
        for (int s = 0; s < depth; s++) n += int'(m_vld(s));
        return n;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the reference, away from the active edge.
    always @(negedge C) begin
        if (chk_en) begin
            chk("q4",    32'(q_a), 32'(m_dat(3)));
            chk("vout4", 32'(v_a), 32'(m_vld(3)));
            chk("fill4", 32'(f_a), 32'(m_fill(4)));
            chk("q1",    32'(q_b), 32'(m_dat(0)));
            chk("vout1", 32'(v_b), 32'(m_vld(0)));
            chk("fill1", 32'(f_b), 32'(m_fill(1)));
`ifdef FDC_PIPE_TAP_EN
            chk("tq4",   32'(tq_a), 32'(m_dat(int'(tap_a))));
            chk("tv4",   32'(tv_a), 32'(m_vld(int'(tap_a))));
            chk("tq1",   32'(tq_b), 32'(m_dat(0)));
            chk("q3",    32'(q_c),  32'(m_dat(2)));
            chk("fill3", 32'(f_c),  32'(m_fill(3)));
            chk("tq3oor", 32'(tq_c), 32'(INIT));
            chk("tv3oor", 32'(tv_c), 32'd0);
`endif
        end
    end

    // Inputs change 1 time unit after the rising edge; returns at edge+1.
    task automatic step(input logic ce, input logic sr, input logic [7:0] d, input logic vin);
        CE = ce; SR = sr; D = d; VIN = vin;
        @(posedge C);
        #1;
    endtask

    task automatic chk4(input string name, input logic [7:0] q, input logic v, input int f);
        chk({name, "_q"},    32'(q_a), 32'(q));
        chk({name, "_vout"}, 32'(v_a), 32'(v));
        chk({name, "_fill"}, 32'(f_a), 32'(f));
    endtask

    logic [7:0] bub_d [4] = '{8'h10, 8'h11, 8'h12, 8'h13};
    logic       bub_v [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    int         bub_f [4] = '{1, 1, 2, 2};

    initial begin
        CLR = 1'b1; CE = 1'b0; SR = 1'b0; D = 8'h00; VIN = 1'b0;
`ifdef FDC_PIPE_TAP_EN
        tap_a = 2'd0;
`endif
        repeat (2) @(posedge C);
        #1;
        CLR = 1'b0;
        chk_en = 1'b1;

        // Load something, then clear asynchronously mid-cycle.
        step(1'b1, 1'b0, 8'h3C, 1'b1);
        step(1'b1, 1'b0, 8'h3D, 1'b1);
        chk4("preclr", 8'hA5, 1'b0, 2);
        chk("preclr_q1", 32'(q_b), 32'h3D);
        #2 CLR = 1'b1;
        #1;
        chk4("clr_now", 8'hA5, 1'b0, 0);
        chk("clr_now_q1", 32'(q_b), 32'hA5);
        chk("clr_now_fill1", 32'(f_b), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 8'h77, 1'b1);
            chk4("clr_held", 8'hA5, 1'b0, 0);
        end
        #1 CLR = 1'b0;

        // Latency and fill ramp.
        for (int i = 1; i <= 5; i++) begin
            step(1'b1, 1'b0, 8'(i), 1'b1);
            chk("lat_fill", 32'(f_a), 32'((i < 4) ? i : 4));
            chk("lat_q1", 32'(q_b), 32'(i));
            if (i == 4) begin
                chk4("lat4", 8'h01, 1'b1, 4);
`ifdef FDC_PIPE_TAP_EN
                tap_a = 2'd2;
                #1;
                chk("tap2_tq", 32'(tq_a), 32'h02);
                chk("tap2_tv", 32'(tv_a), 32'd1);
                chk("tap3oor_tq", 32'(tq_c), 32'hA5);
                chk("tap3oor_tv", 32'(tv_c), 32'd0);
`endif
            end
        end
        chk4("lat5", 8'h02, 1'b1, 4);

        // Stall with three words loaded.
        step(1'b1, 1'b1, 8'h00, 1'b0);
        chk4("sr_clear", 8'hA5, 1'b0, 0);
        step(1'b1, 1'b0, 8'h21, 1'b1);
        step(1'b1, 1'b0, 8'h22, 1'b1);
        step(1'b1, 1'b0, 8'h23, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 8'($urandom), 1'b1);
            chk4("stall", 8'hA5, 1'b0, 3);
        end
        step(1'b1, 1'b0, 8'h24, 1'b1);
        chk4("resume1", 8'h21, 1'b1, 4);
        step(1'b1, 1'b0, 8'h25, 1'b1);
        chk4("resume2_full", 8'h22, 1'b1, 4);

        // SR together with CE on a full pipeline: nothing captured.
        step(1'b1, 1'b1, 8'hFF, 1'b1);
        chk4("sr_prio", 8'hA5, 1'b0, 0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'h00, 1'b0);
        chk4("sr_nocap", 8'hA5, 1'b0, 0);
        step(1'b1, 1'b0, 8'h00, 1'b0);
        chk4("sr_after", 8'h00, 1'b0, 0);

        // Bubbles.
        step(1'b1, 1'b1, 8'h00, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, bub_d[i], bub_v[i]);
            chk("bub_fill", 32'(f_a), 32'(bub_f[i]));
            chk("bub_q1", 32'(q_b), 32'(bub_d[i]));
            chk("bub_v1", 32'(v_b), 32'(bub_v[i]));
        end
        chk4("bub4", 8'h10, 1'b1, 2);
        step(1'b1, 1'b0, 8'h00, 1'b0);
        chk4("bub5", 8'h11, 1'b0, 1);
        step(1'b1, 1'b0, 8'h00, 1'b0);
        chk4("bub6", 8'h12, 1'b1, 1);
        step(1'b1, 1'b0, 8'h00, 1'b0);
        chk4("bub7", 8'h13, 1'b0, 0);

        // Randomised traffic with occasional stalls, resets and clears.
        for (int i = 0; i < 1500; i++) begin
`ifdef FDC_PIPE_TAP_EN
            tap_a = 2'($urandom_range(0, 3));
`endif
            step(($urandom_range(0, 9) < 7), ($urandom_range(0, 49) == 0),
                 8'($urandom), 1'($urandom));
            if ($urandom_range(0, 99) == 0) begin
                #1 CLR = 1'b1;
                #1 CLR = 1'b0;
            end
        end

        @(posedge C);
        #1;
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fdc_pipe.md
Name: fdc_pipe

Overview:
- Parametrised successor to the single-bit async-clear D flip-flop.
- WIDTH-bit by DEPTH-stage register pipeline (delay line) with per-stage valid tracking.
- Each stage supports async clear to a parameterised INIT value, clock enable and synchronous reset.
- Used as a generic retiming/delay primitive in datapaths that need a fixed, stallable latency with a fill-level indication.

Parameters:
- WIDTH, 8, data bits per stage (>=1)
- DEPTH, 4, number of stages = latency in enabled cycles (>=1; 0 is illegal, elaboration error)
- INIT, {WIDTH{1'b0}}, WIDTH-bit value loaded into every data stage on CLR or SR

Ports:
- C  in  1  clock, rising edge
- CLR  in  1  asynchronous active-high clear
- CE  in  1  clock enable; shift only when 1
- SR  in  1  synchronous active-high reset, sampled on rising C
- D  in  WIDTH  data into stage 0
- VIN  in  1  valid qualifier for D
- Q  out  WIDTH  data of stage DEPTH-1
- VOUT  out  1  valid bit of stage DEPTH-1
- FILL  out  $clog2(DEPTH+1)  number of stages currently holding valid=1

Behaviour:
- State: data[0..DEPTH-1] (WIDTH each), vld[0..DEPTH-1], fill counter.
- CLR=1 (async, immediate, no clock needed):
  - all data[i]=INIT, all vld[i]=0, FILL=0, so Q=INIT, VOUT=0.
  - Held for as long as CLR=1; all other inputs are ignored.
- Priority at rising C with CLR=0: SR > CE > hold.
- SR=1: all data[i]=INIT, vld[i]=0, FILL=0 at that edge, regardless of CE.
- CE=1, SR=0, shift:
  - data[0]<=D, vld[0]<=VIN.
  - data[i]<=data[i-1], vld[i]<=vld[i-1] for i=1..DEPTH-1.
  - FILL <= FILL + VIN - vld[DEPTH-1] (old value).
- CE=0, SR=0: every register holds, including FILL.
- Latency: D/VIN accepted at enabled edge k appear on Q/VOUT after enabled edge k+DEPTH-1, i.e. DEPTH enabled edges including the capture edge. Disabled cycles do not count.
- Data moves on every enabled edge even when VIN=0. Valid is tracking only and never gates the data shift.
- Boundaries:
  - FILL never exceeds DEPTH. Simultaneous VIN=1 with vld[DEPTH-1]=1 keeps FILL constant. With FILL=DEPTH, VIN=1 leaves FILL=DEPTH.
  - DEPTH=1: single register, Q follows D one enabled edge later, FILL in {0,1}.
  - CLR deasserting near a C edge: the design is not required to capture on that edge. The first guaranteed capture is on the following edge.
  - SR and CE asserted together: SR wins, no data is captured.
- Q, VOUT and FILL are registered outputs only. There is no combinational path from inputs to outputs.

Optional Feature:
- Macro FDC_PIPE_TAP_EN.
- When defined, adds ports:
  - TAP  in  $clog2(DEPTH) (min 1)  stage select
  - TQ  out  WIDTH  combinational data[TAP]
  - TV  out  1  combinational vld[TAP]
- If TAP >= DEPTH, then TQ=INIT and TV=0.
- When undefined, these ports and the mux do not exist. Core behaviour is identical in both builds.

Decomposition:
- Package fdc_pipe_pkg:
  - function for the FILL width, clog2(DEPTH+1)
  - function for the TAP width, max(1, clog2(DEPTH))
  - localparam FILL_MAX = DEPTH
- Sub-module fdc_stage: one WIDTH+1-bit register (data plus valid) with async CLR to {INIT,0}, SR and CE using the priority above. It is instantiated DEPTH times in a generate loop. The FILL counter lives in the top module.

Test Plan (WIDTH=8, DEPTH=4, INIT=8'hA5 unless noted):
- Reset: pulse CLR mid-cycle with no clock -> Q=8'hA5, VOUT=0, FILL=0 immediately. Toggling C with CLR held produces no change.
- Latency: CE=1, feed D=01,02,03,04,05 with VIN=1 on consecutive edges -> Q=01 and VOUT=1 after the 4th edge, FILL sequence 1,2,3,4,4.
- Stall: after loading 3 values, hold CE=0 for 5 cycles with D changing -> Q, VOUT and FILL are frozen. Resume CE=1 -> outputs continue with no lost or duplicated values.
- Sync reset priority: pipeline full (FILL=4), assert SR=1 and CE=1 with D=FF on one edge -> next cycle Q=A5, VOUT=0, FILL=0. Data FF is not captured.
- Bubbles: VIN pattern 1,0,1,0 with D=10,11,12,13 -> VOUT pattern 1,0,1,0 after 4 edges, Q=10,11,12,13, FILL peaks at 2.
- DEPTH=1 plus FDC_PIPE_TAP_EN (separate build uses DEPTH=4):
  - DEPTH=1: Q=D one enabled edge later.
  - DEPTH=4 with TAP=2 after loading 01..04 -> TQ=02, TV=1.
  - Forcing an out-of-range TAP (parameter override to DEPTH=3, TAP=3) -> TQ=A5, TV=0.
